// File: rtl/pulse_sched_pkg.sv
// Shared types and helpers for pulse_scheduler: FSM state encoding, phase
// counter width and a burst-length field extractor for the packed bus.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int PHASE_W     = 32;
  localparam int MAX_REQ     = 8;
  localparam int MAX_COUNT_W = 16;
  localparam int MAX_BUS_W   = MAX_REQ * MAX_COUNT_W;

  // Field idx of a bus packed as idx*cw +: cw, zero-extended to MAX_COUNT_W.
  function automatic logic [MAX_COUNT_W-1:0] burst_field(
    input logic [MAX_BUS_W-1:0] bus,
    input int unsigned          idx,
    input int unsigned          cw
  );
    logic [MAX_BUS_W-1:0]   sh;
    logic [MAX_COUNT_W-1:0] mask;
    sh   = bus >> (idx * cw);
    mask = MAX_COUNT_W'((32'd1 << cw) - 32'd1);
    return sh[MAX_COUNT_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from
// ptr_i, wrapping modulo NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  always_comb begin
    int               cand;
    logic [PTR_W-1:0] ci;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    ci      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      ci   = PTR_W'(cand);
      if (!valid_o && req_i[ci]) begin
        valid_o     = 1'b1;
        idx_o       = ci;
        grant_o[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_scheduler.sv
// Round-robin sharing of one pulse output among NUM_REQ burst requesters.
// Optional feature macro: PULSE_SCHED_ABORT_EN (owner dropping req aborts its burst).
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PERIOD      = 12000000,
  parameter int PULSE_WIDTH = 6000000,
  parameter int COUNT_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*COUNT_W-1:0] burst_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       busy,
  output logic                       out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PHASE_W-1:0] HIGH_LAST = PHASE_W'(PULSE_WIDTH - 1);
  localparam logic [PHASE_W-1:0] LOW_LAST  = PHASE_W'(PERIOD - PULSE_WIDTH - 1);

  // Handshake: a requester raises req and holds it until its one-cycle done
  // strobe; grant marks the owner from the cycle after pick until after done.
  state_e               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [COUNT_W-1:0]   remaining_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;
  logic                 out_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [PTR_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [MAX_BUS_W-1:0] burst_bus;
  logic [COUNT_W-1:0]   win_len;
  logic [PTR_W-1:0]     next_ptr;
  logic                 abort_c;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign burst_bus = MAX_BUS_W'(burst_len);
  assign win_len   = COUNT_W'(burst_field(burst_bus, 32'(arb_idx), COUNT_W));
  assign next_ptr  = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + PTR_W'(1);

`ifdef PULSE_SCHED_ABORT_EN
  assign abort_c = ~|(req & grant_q);
`else
  assign abort_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      phase_q     <= '0;
      remaining_q <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q     <= arb_grant;
            remaining_q <= win_len;
            ptr_q       <= next_ptr;
            phase_q     <= '0;
            busy_q      <= 1'b1;
            if (win_len == '0) begin
              state_q <= ST_DONE;
            end else begin
              out_q   <= 1'b1;
              state_q <= ST_HIGH;
            end
          end
        end
        ST_HIGH: begin
          if (abort_c) begin
            out_q   <= 1'b0;
            done_q  <= grant_q;
            state_q <= ST_DONE;
          end else if (phase_q == HIGH_LAST) begin
            out_q   <= 1'b0;
            phase_q <= '0;
            state_q <= ST_LOW;
          end else begin
            phase_q <= phase_q + PHASE_W'(1);
          end
        end
        ST_LOW: begin
          if (abort_c) begin
            done_q  <= grant_q;
            state_q <= ST_DONE;
          end else if (phase_q == LOW_LAST) begin
            phase_q     <= '0;
            remaining_q <= remaining_q - COUNT_W'(1);
            if (remaining_q == COUNT_W'(1)) begin
              done_q  <= grant_q;
              state_q <= ST_DONE;
            end else begin
              out_q   <= 1'b1;
              state_q <= ST_HIGH;
            end
          end else begin
            phase_q <= phase_q + PHASE_W'(1);
          end
        end
        ST_DONE: begin
          // A zero-length grant arrives here without a strobe yet; issue it first.
          if (done_q == '0) begin
            done_q <= grant_q;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign out   = out_q;

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Shares one pulse output, normally a board LED or trigger pin, between `NUM_REQ` requesters in round-robin order. Each requester asks for a burst of N fixed-shape pulses. The scheduler grants one requester at a time, plays its burst, and signals completion. It sits between status sources (serial receiver, error flags, heartbeat) and the single physical output.

## Interface
- `NUM_REQ`, 4: number of requesters; valid range is 2 to 8.
- `PERIOD`, 12000000: pulse period, in clk cycles.
- `PULSE_WIDTH`, 6000000: high time per pulse, in clk cycles. Requires 0 < `PULSE_WIDTH` < `PERIOD`.
- `COUNT_W`, 4: width of each requester's burst-length field.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  request level per requester; held high until that requester's `done`.
- `burst_len`  in  `NUM_REQ*COUNT_W`  packed burst lengths; field i is bits [i*COUNT_W +: COUNT_W].
- `grant`  out  `NUM_REQ`  one-hot, or all zero; the current owner.
- `done`  out  `NUM_REQ`  one-cycle completion strobe to the owner.
- `busy`  out  1  high whenever the state is not IDLE.
- `out`  out  1  shared pulse output.

## Operation
- All outputs are registered.
- Reset values: `out`=0, `grant`=0, `done`=0, `busy`=0, state=IDLE, RR pointer=0 (`req[0]` has highest priority first).
- **IDLE**
  - With no `req`, stay in IDLE.
  - Otherwise pick the winner: the first set `req` bit scanning upward from the RR pointer, wrapping modulo `NUM_REQ`.
  - Latch `remaining` = winner's `burst_len`.
  - Set RR pointer = winner+1, mod `NUM_REQ`.
  - Set `grant`.
  - If `remaining`=0, go to DONE.
  - Otherwise set the phase counter to 0, `out`=1, and go to HIGH.
- **HIGH**
  - Count `PULSE_WIDTH` cycles with `out`=1.
  - On the last cycle: `out`←0 and go to LOW.
- **LOW**
  - Count `PERIOD`−`PULSE_WIDTH` cycles with `out`=0.
  - On the last cycle, decrement `remaining`.
  - If the decremented value is 0, go to DONE.
  - Otherwise set `out`←1 and go to HIGH.
- **DONE**
  - `done[winner]`=1 for exactly one cycle; `grant` is still held.
  - Next cycle: `grant`←0 and go to IDLE.
- `burst_len` is sampled only at grant; later changes are ignored.
- The phase counter is 32 bits and saturation-free; parameter rules guarantee no overflow.
- Requests that arrive while busy wait. There is no queueing beyond the `req` level.
- `grant` and `done` are never set for a non-owner.

## Timing
- **Grant latency:** `req` is sampled in IDLE at cycle t. `grant` and `out`=1 appear at t+1.
- **Burst length:** a burst of N≥1 gives `out` high exactly `PULSE_WIDTH` cycles per pulse, with pulses starting every `PERIOD` cycles. `done` occurs at t+1+N·`PERIOD`.
- **Zero-length burst:** N=0 gives `done` at t+2 and no pulse.
- **Back-to-back bursts:** the minimum `out`-low gap between different owners' bursts is `PERIOD`−`PULSE_WIDTH`+2 cycles (DONE plus IDLE).
- **Reset mid-burst:** all outputs return to reset values the cycle after `rst` is seen. No `done` is issued for the interrupted burst.
- **Simultaneous events:** `req` rising in the same cycle as another requester's `done` is seen in the following IDLE cycle.

## Configuration
- `PULSE_SCHED_ABORT_EN` defined:
  - If the owner drops `req` while in HIGH or LOW, the scheduler forces `out`←0 and goes to DONE on the next cycle.
  - The owner still receives a `done` strobe.
- Undefined: `req` is not examined after grant, and the burst always completes.

## Structure
- `pulse_sched_pkg` holds:
  - the state enum (IDLE, HIGH, LOW, DONE);
  - `PHASE_W`=32;
  - a function that extracts requester i's burst-length field.
- Sub-module `rr_arbiter`:
  - combinational round-robin pick from `req` and the pointer;
  - outputs a one-hot winner and a `valid` flag;
  - the scheduler owns the pointer register.

## Test plan
Tests use `PERIOD`=10, `PULSE_WIDTH`=4, `NUM_REQ`=4, `COUNT_W`=4.
- **Single burst:** `req`=0001 with len 3 → `out` shows 3 pulses of 4 high / 6 low; `done[0]` at t+31; `grant` clears at t+32.
- **Round robin:** `req`=1111 held, all len 1 → grant order is 0, 1, 2, 3, 0; each `done` comes 12 cycles after the previous one.
- **Zero length:** `req`=0100 with len 0 → `grant`=0100 at t+1, `done[2]` at t+2, `out` never high.
- **Reset mid-burst:** `rst` at cycle 15 of a 3-pulse burst → `out`, `grant`, `busy` and `done` are all 0 the next cycle, and `req[0]` is granted first afterwards.
- **Abort:** with `PULSE_SCHED_ABORT_EN`, drop `req[1]` mid-HIGH → `out`=0 and `done[1]` the next cycle.
- **Abort ignored:** without the macro, the same stimulus → the full burst completes.
